serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor for the arithmetic-operations library. It loads two WIDTH-bit operands in parallel on a `start` pulse and computes `a - b` LSB-first, one bit per clock. Each bit is computed by a single full-adder cell fed `a`, inverted `b` and the running carry. The result and borrow are presented with a one-cycle `done` pulse. It is the subtraction counterpart of the combinational adder cells, trading latency for a one-bit datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 and up.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request to begin a subtraction; sampled on the rising edge of `clk`.
- `a` input, WIDTH bits: minuend; captured on the edge where `start` is accepted.
- `b` input, WIDTH bits: subtrahend; captured on the same edge.
- `busy` output, 1 bit: high while a subtraction is in progress.
- `done` output, 1 bit: one-cycle pulse meaning `diff`/`borrow` are valid.
- `diff` output, WIDTH bits: `(a - b) mod 2^WIDTH`.
- `borrow` output, 1 bit: 1 when a < b (unsigned comparison).
- `ovf` output, 1 bit: signed overflow flag; present only when `SERIAL_SUB_OVF_EN` is defined.

## Operation
- State machine has three states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE, or DONE, with `start`=1:
  - copy `a` and `b` into shift registers;
  - set carry to 1 (computes a + ~b + 1);
  - clear the bit counter;
  - go to RUN.
- IDLE or DONE with `start`=0: IDLE stays in IDLE; DONE returns to IDLE.
- RUN, on each edge:
  - form s = a0 ^ ~b0 ^ c and c' = majority(a0, ~b0, c);
  - shift s into `diff` at the MSB and shift the `diff` register right;
  - shift the operand registers right;
  - increment the counter.
- RUN exits to DONE on the edge that processes bit WIDTH-1. On that edge:
  - `borrow` is set to ~c';
  - `ovf` is set to (carry into the MSB) ^ c'.
- `start` is ignored in RUN. Changes on `a`/`b` after capture have no effect.
- `busy` = (state == RUN). `done` = (state == DONE).
- `diff`, `borrow` and `ovf` hold their values after DONE until the next accepted `start`.
- While RUN is in progress, `diff` shows partial shift contents. It is only meaningful while `done`=1 or afterwards in IDLE.
- Bit-counter width is $clog2(WIDTH). There is no wrap-around hazard because the exit condition is count == WIDTH-1.

## Timing
- Reset (asynchronous): state=IDLE. `busy`, `done`, `diff`, `borrow`, `ovf` and the counter are all 0; the internal carry is 0.
- Reset asserted mid-RUN aborts the operation immediately. No `done` is produced, and the next `start` after reset release works normally.
- Let edge E0 be the edge where `start` is accepted:
  - `busy`=1 after edges E0 through E(WIDTH-1);
  - `done`=1 and the result is valid after edge E(WIDTH), i.e. WIDTH cycles after acceptance;
  - `done` drops after E(WIDTH+1).
- Back-to-back operation: `start`=1 during the DONE cycle is accepted. The next result arrives WIDTH cycles later, giving a throughput of one result per WIDTH+1 cycles.
- There is no combinational path from any input to any output; all outputs are registered.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- When defined, the `ovf` port exists. It is registered on the final RUN edge, cleared by reset, and held like `borrow`. It is 1 when the signed result does not fit in WIDTH bits, e.g. 0x80 - 0x01.
- When undefined, there is no `ovf` port and no MSB-carry tracking register. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x05, b=0x03, `start` for one cycle -> `done`=1 exactly 8 cycles after acceptance, with `diff`=0x02, `borrow`=0, and `busy` high for 8 cycles.
- a=0x03, b=0x05 -> `diff`=0xFE, `borrow`=1. Also a=0x00, b=0x00 -> `diff`=0x00, `borrow`=0.
- With `SERIAL_SUB_OVF_EN`:
  - a=0x80, b=0x01 -> `diff`=0x7F, `borrow`=0, `ovf`=1;
  - a=0x7F, b=0xFF -> `diff`=0x80, `borrow`=1, `ovf`=1;
  - a=0x10, b=0x01 -> `ovf`=0.
- Hold `start`=1 and change `a`/`b` every cycle during RUN -> the result reflects only the operands captured at E0, and exactly one `done` pulse occurs per accepted `start`.
- Assert `rst` during the 4th RUN cycle -> all outputs 0 immediately and no `done`. After release, a=0xFF, b=0x01 -> `diff`=0xFE, `borrow`=0.
- `start` during the DONE cycle with new operands a=0x20, b=0x30 -> a new run begins without an IDLE cycle, producing `diff`=0xF0, `borrow`=1 eight cycles later.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  // One full-adder cell fed a, ~b and the running carry.
  logic nb0;
  logic sum_d;
  logic carry_d;

  assign nb0     = ~b_q[0];
  assign sum_d   = a_q[0] ^ nb0 ^ carry_q;
  assign carry_d = (a_q[0] & nb0) | (a_q[0] & carry_q) | (nb0 & carry_q);

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b1;  // a + ~b + 1
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          diff_q  <= {sum_d, diff_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_q  <= DONE;
            borrow_q <= ~carry_d;
`ifdef SERIAL_SUB_OVF_EN
            // carry_q here is the carry into the MSB cell
            ovf_q    <= carry_q ^ carry_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): cycle-level arithmetic model
// plus directed vectors with literal expectations.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts cycles since acceptance, computes results arithmetically.
  int               m_left   = 0;
  logic             m_done   = 1'b0;
  logic [WIDTH-1:0] m_diff   = '0;
  logic             m_borrow = 1'b0;
  logic             m_ovf    = 1'b0;
  logic [WIDTH-1:0] p_diff;
  logic             p_borrow;
  logic             p_ovf;
  int               sa, sb, sd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_diff = '0; m_borrow = 1'b0; m_ovf = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf;
      end
    end else if (start) begin
      p_diff   = a - b;
      p_borrow = (a < b);
      sa = $signed(a);
      sb = $signed(b);
      sd = sa - sb;
      p_ovf  = (sd > 127) || (sd < -128);
      m_left = WIDTH;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("model_busy", busy, m_left > 0);
      check("model_done", done, m_done);
      if (m_left == 0) begin
        check("model_diff", diff, m_diff);
        check("model_borrow", borrow, m_borrow);
`ifdef SERIAL_SUB_OVF_EN
        check("model_ovf", ovf, m_ovf);
`endif
      end
    end
  end

  // Drives one start pulse; returns just after start is dropped (after E0).
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk);
    #1;
    check("busy_after_accept", busy, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (done) break;
    end
    check({name, "_latency"}, n, 8);
    check({name, "_diff"}, diff, ed);
    check({name, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({name, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
  endtask

  task automatic count_done(input string name, input int cycles, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check(name, n, exp);
  endtask

  initial begin
    int k;
    int busy_cnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    rst = 1'b0;

    // Basic subtraction, busy counted over the whole run.
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03;
    busy_cnt = 0;
    @(posedge clk); #1;
    if (busy) busy_cnt++;
    @(negedge clk); start = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      k = i;
      if (busy) busy_cnt++;
      if (done) break;
    end
    check("basic_latency", k, 8);
    check("basic_busy_cycles", busy_cnt, 8);
    check("basic_diff", diff, 8'h02);
    check("basic_borrow", borrow, 0);
    @(posedge clk); #1;
    check("basic_done_drops", done, 0);

    launch(8'h03, 8'h05); wait_result("neg", 8'hFE, 1'b1, 1'b0);
    launch(8'h00, 8'h00); wait_result("zero", 8'h00, 1'b0, 1'b0);
    launch(8'h80, 8'h01); wait_result("ovf_pos", 8'h7F, 1'b0, 1'b1);
    launch(8'h7F, 8'hFF); wait_result("ovf_neg", 8'h80, 1'b1, 1'b1);
    launch(8'h10, 8'h01); wait_result("no_ovf", 8'h0F, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // start held high while operands churn during RUN.
    @(negedge clk);
    start = 1'b1; a = 8'h44; b = 8'h11;
    @(posedge clk); #1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      k = i;
      if (done) break;
    end
    check("hold_latency", k, 8);
    check("hold_diff", diff, 8'h33);
    check("hold_borrow", borrow, 0);
    @(negedge clk);
    start = 1'b0;
    count_done("hold_no_extra_done", 12, 0);

    // Reset during the 4th RUN cycle.
    launch(8'h55, 8'h22);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow, 0);
    @(negedge clk);
    rst = 1'b0;
    count_done("midrst_no_done", 12, 0);
    launch(8'hFF, 8'h01); wait_result("after_rst", 8'hFE, 1'b0, 1'b0);

    // Back-to-back: new start during the DONE cycle.
    launch(8'h40, 8'h10); wait_result("b2b_first", 8'h30, 1'b0, 1'b0);
    launch(8'h20, 8'h30); wait_result("b2b_second", 8'hF0, 1'b1, 1'b0);
    count_done("b2b_single_done", 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
